toggle_activity_counter: RTL and testbench

Downstream consumer of the mux4x1 datapath nets: the input bus is {out, sel[1:0], d, c, b, a}, with a at bit 0.
- Samples the nets every clock over a programmable window and counts per-bit 0↔1 transitions.
- Streams the per-signal toggle counts out through a valid/ready interface.
- Provides the switching-activity numbers that the power estimator multiplies by per-net capacitance, replacing offline VCD post-processing.

---
 rtl/toggle_pkg.sv | 23 ++
 rtl/toggle_counter_cell.sv | 32 +++
 rtl/toggle_activity_counter.sv | 115 +++++++++++
 tb/tb_toggle_activity_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and constants for the toggle activity counter.
// Index constants follow the mux4x1 net order {out, sel[1:0], d, c, b, a}.
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    DRAIN
  } state_t;

  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

  localparam int A    = 0;
  localparam int B    = 1;
  localparam int C    = 2;
  localparam int D    = 3;
  localparam int SEL0 = 4;
  localparam int SEL1 = 5;
  localparam int OUT  = 6;

endpackage

// File: rtl/toggle_counter_cell.sv
// One monitored net: previous-sample bit plus a saturating toggle counter.
module toggle_counter_cell #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             arm,
  input  logic             en,
  input  logic             sig,
  output logic [CNT_W-1:0] cnt
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else if (clear) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else if (arm) begin
      prev <= sig;
    end else if (en) begin
      prev <= sig;
      if ((sig != prev) && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/toggle_activity_counter.sv
// Windowed per-net toggle counter with a valid/ready drain of the counts.
// FSM: IDLE -> ARM (baseline) -> COUNT (win_len compares) -> DRAIN (NUM_SIG beats).
module toggle_activity_counter
  import toggle_pkg::*;
#(
  parameter int NUM_SIG = 7,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_W   = 16,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [NUM_SIG-1:0] sig_in,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_last,
  output logic               done
);

  state_t           state, next_state;
  logic             clear, arm, en, load_win, idx_inc, finish;
  logic             hs;
  logic [WIN_W-1:0] win_rem;
  logic [CNT_W-1:0] cnt_arr [NUM_SIG];

  for (genvar i = 0; i < NUM_SIG; i++) begin : g_cell
    toggle_counter_cell #(.CNT_W(CNT_W)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .arm  (arm),
      .en   (en),
      .sig  (sig_in[i]),
      .cnt  (cnt_arr[i])
    );
  end

  assign hs        = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign out_last  = out_valid && (out_idx == IDX_W'(NUM_SIG - 1));
  assign out_count = cnt_arr[out_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    arm        = 1'b0;
    en         = 1'b0;
    load_win   = 1'b0;
    idx_inc    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        // done marks the cycle right after a drain; a start there is refused.
        if (start && !done) begin
          clear      = 1'b1;
          load_win   = 1'b1;
          next_state = (win_len == '0) ? DRAIN : ARM;
        end
      end
      ARM: begin
        arm        = 1'b1;
        next_state = COUNT;
      end
      COUNT: begin
        en = 1'b1;
        if (win_rem == WIN_W'(1)) next_state = DRAIN;
      end
      DRAIN: begin
        if (hs) begin
          if (out_last) begin
            finish     = 1'b1;
            next_state = IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_rem   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;

      if (load_win)  win_rem <= win_len;
      else if (en)   win_rem <= win_rem - 1'b1;

      if (finish || load_win) out_idx <= '0;
      else if (idx_inc)       out_idx <= out_idx + 1'b1;

      // A zero window enters DRAIN straight from IDLE, so valid rises one cycle into DRAIN.
      if (state == COUNT && win_rem == WIN_W'(1)) out_valid <= 1'b1;
      else if (state == DRAIN)                     out_valid <= !finish;
      else                                         out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Bench: two instances (16-bit and 4-bit counters) share all inputs;
// expected counts come from the list of applied vectors.
module tb_toggle_activity_counter;

  localparam int NUM_SIG = 7;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;
  localparam int WIN_W   = 16;
  localparam int IDX_W   = 3;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic [WIN_W-1:0]   win_len;
  logic [NUM_SIG-1:0] sig_in;

  logic               busy, out_valid, out_last, done;
  logic [IDX_W-1:0]   out_idx;
  logic [CNT_W-1:0]   out_count;
  logic               s_busy, s_valid, s_last, s_done;
  logic [IDX_W-1:0]   s_idx;
  logic [SAT_W-1:0]   s_count;

  toggle_activity_counter #(
    .NUM_SIG(NUM_SIG), .CNT_W(CNT_W), .WIN_W(WIN_W), .IDX_W(IDX_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig_in(sig_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_count(out_count), .out_last(out_last), .done(done)
  );

  toggle_activity_counter #(
    .NUM_SIG(NUM_SIG), .CNT_W(SAT_W), .WIN_W(WIN_W), .IDX_W(IDX_W)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig_in(sig_in),
    .busy(s_busy), .out_valid(s_valid), .out_ready(out_ready), .out_idx(s_idx),
    .out_count(s_count), .out_last(s_last), .done(s_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NUM_SIG-1:0] vecs[$];
  int                 exp_cnt[NUM_SIG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected toggles: number of adjacent vector pairs that differ in bit i.
  function automatic void compute_expected();
    for (int i = 0; i < NUM_SIG; i++) begin
      int n = 0;
      for (int k = 1; k < vecs.size(); k++)
        if (vecs[k][i] != vecs[k-1][i]) n++;
      exp_cnt[i] = n;
    end
  endfunction

  // vecs must hold win+1 entries: baseline then one per compare cycle.
  task automatic run_window(input int win);
    compute_expected();
    start   = 1'b1;
    win_len = WIN_W'(win);
    tick();
    start   = 1'b0;
    win_len = WIN_W'($urandom);
    check("busy_after_start", 32'(busy), 1);
    for (int k = 0; k <= win; k++) begin
      sig_in = vecs[k];
      if (k == win) check("valid_early", 32'(out_valid), 0);
      tick();
    end
    sig_in = NUM_SIG'($urandom);
    check("valid_latency", 32'(out_valid), 1);
  endtask

  task automatic drain(input int stall_idx, input int stall_n, input bit poke_start);
    out_ready = 1'b1;
    for (int j = 0; j < NUM_SIG; j++) begin
      int sat_exp = (exp_cnt[j] > SAT_MAX) ? SAT_MAX : exp_cnt[j];
      check($sformatf("valid_%0d", j), 32'(out_valid), 1);
      check($sformatf("idx_%0d", j), 32'(out_idx), 32'(j));
      check($sformatf("count_%0d", j), 32'(out_count), 32'(exp_cnt[j]));
      check($sformatf("sat_count_%0d", j), 32'(s_count), 32'(sat_exp));
      check($sformatf("last_%0d", j), 32'(out_last), 32'(j == NUM_SIG - 1));
      if (j == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          if (poke_start && s == 0) begin
            start   = 1'b1;
            win_len = WIN_W'(5);
          end
          sig_in = NUM_SIG'($urandom);
          tick();
          start = 1'b0;
          check($sformatf("stall_idx_%0d", s), 32'(out_idx), 32'(j));
          check($sformatf("stall_count_%0d", s), 32'(out_count), 32'(exp_cnt[j]));
          check($sformatf("stall_valid_%0d", s), 32'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", 32'(done), 1);
    check("sat_done_pulse", 32'(s_done), 1);
    check("valid_after_last", 32'(out_valid), 0);
    check("busy_after_last", 32'(busy), 0);
    // A start in the done cycle must be refused.
    start   = 1'b1;
    win_len = WIN_W'(3);
    tick();
    start = 1'b0;
    check("start_on_done_ignored", 32'(busy), 0);
    check("done_single_cycle", 32'(done), 0);
  endtask

  initial begin
    logic [1:0]         sels[8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3};
    logic [3:0]         abcd[8] = '{4'b1011, 4'b1101, 4'b0011, 4'b1111,
                                    4'b1000, 4'b1001, 4'b0010, 4'b0000};
    logic [3:0]         dcba;
    logic [NUM_SIG-1:0] v;
    bit                 seen_done;
    int                 win;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    win_len   = '0;
    sig_in    = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_done", 32'(done), 0);
    check("rst_idx", 32'(out_idx), 0);
    check("rst_sat_busy", 32'(s_busy), 0);
    rst = 1'b0;
    tick();

    // Basic window: only bit a toggles.
    vecs.delete();
    for (int k = 0; k <= 4; k++) vecs.push_back({6'b101100, k[0]});
    run_window(4);
    check("basic_a_model", 32'(exp_cnt[toggle_pkg::A]), 4);
    drain(-1, 0, 1'b0);

    // Mux replay; out is recomputed from sel/a..d, last vector held.
    vecs.delete();
    for (int k = 0; k <= 8; k++) begin
      int s = (k > 7) ? 7 : k;
      dcba = {abcd[s][0], abcd[s][1], abcd[s][2], abcd[s][3]};
      v    = {dcba[sels[s]], sels[s], dcba};
      vecs.push_back(v);
    end
    run_window(8);
    drain(-1, 0, 1'b0);

    // Saturation on bit c plus backpressure and a start poke during DRAIN.
    vecs.delete();
    for (int k = 0; k <= 20; k++) begin
      v    = NUM_SIG'($urandom);
      v[toggle_pkg::C] = k[0];
      vecs.push_back(v);
    end
    run_window(20);
    check("sat_model_c", 32'(exp_cnt[toggle_pkg::C]), 20);
    drain(3, 5, 1'b1);

    // Zero window.
    vecs.delete();
    vecs.push_back(NUM_SIG'($urandom));
    run_window(0);
    drain(-1, 0, 1'b0);

    // Reset mid-COUNT: asynchronous abort, no done.
    start   = 1'b1;
    win_len = WIN_W'(10);
    tick();
    start = 1'b0;
    repeat (4) begin
      sig_in = NUM_SIG'($urandom);
      tick();
    end
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    tick();
    rst       = 1'b0;
    seen_done = 1'b0;
    out_ready = 1'b1;
    repeat (15) begin
      tick();
      if (done || out_valid) seen_done = 1'b1;
    end
    check("no_output_after_abort", 32'(seen_done), 0);

    // Fresh runs with random windows and vectors.
    for (int r = 0; r < 3; r++) begin
      win = (r == 0) ? 6 : int'($urandom_range(1, 40));
      vecs.delete();
      for (int k = 0; k <= win; k++) vecs.push_back(NUM_SIG'($urandom));
      run_window(win);
      drain(int'($urandom_range(0, NUM_SIG - 1)), int'($urandom_range(1, 4)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
